// File: rtl/object_centroid_reader_pkg.sv
// Shared definitions for the object centroid reader: default widths and the
// sweep state encoding.
package object_centroid_reader_pkg;

   localparam int DEF_LBL_WIDTH = 8;
   localparam int DEF_LOC_SIZE  = 16;

   typedef enum logic [2:0] {
      CR_IDLE,
      CR_ISSUE,
      CR_WAIT,
      CR_CAPTURE,
      CR_DIVIDE,
      CR_EMIT,
      CR_FIN
   } cr_state_t;

endpackage

// File: rtl/object_centroid_reader_udiv_seq.sv
// Unsigned restoring divider producing one quotient bit per clock.
// The first bit is resolved on the loading edge, so a result is ready WIDTH edges after start.
module udiv_seq
   import object_centroid_reader_pkg::*;
#(
   parameter int WIDTH = DEF_LOC_SIZE
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic [WIDTH-1:0] quotient
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [CNT_W-1:0] steps_left;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] divisor_q;
   logic [WIDTH-1:0] src_rem;
   logic [WIDTH-1:0] src_quo;
   logic [WIDTH-1:0] src_div;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             take;

   assign busy = (steps_left != '0);

   // The quotient register doubles as the dividend shift register; a start
   // takes its operands straight from the ports instead of the held state.
   always_comb begin
      src_rem = start ? '0 : rem;
      src_quo = start ? dividend : quotient;
      src_div = start ? divisor : divisor_q;
      shifted = {src_rem, src_quo[WIDTH-1]};
      take    = (shifted >= {1'b0, src_div});
      diff    = shifted[WIDTH-1:0] - src_div;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         steps_left <= '0;
         rem        <= '0;
         divisor_q  <= '0;
         quotient   <= '0;
      end else if (start || busy) begin
         rem        <= take ? diff : shifted[WIDTH-1:0];
         quotient   <= {src_quo[WIDTH-2:0], take};
         divisor_q  <= src_div;
         steps_left <= start ? CNT_W'(WIDTH - 1) : steps_left - 1'b1;
      end
   end

endmodule

// File: rtl/object_centroid_reader.sv
// Post-frame sweep of the labeller's object table: reads each label's area and
// coordinate sums, divides them into a centroid and streams one record per object.
module object_centroid_reader
   import object_centroid_reader_pkg::*;
#(
   parameter int LBL_WIDTH  = DEF_LBL_WIDTH,
   parameter int LOC_SIZE   = DEF_LOC_SIZE,
   parameter int RD_LATENCY = 2,
   parameter int MIN_AREA   = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [LBL_WIDTH-1:0] num_labels,
   output logic [LBL_WIDTH-1:0] obj_id,
   input  logic [LOC_SIZE-1:0]  obj_area,
   input  logic [LOC_SIZE-1:0]  obj_x,
   input  logic [LOC_SIZE-1:0]  obj_y,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LBL_WIDTH-1:0] out_id,
   output logic [LOC_SIZE-1:0]  out_area,
   output logic [LOC_SIZE-1:0]  out_cx,
   output logic [LOC_SIZE-1:0]  out_cy,
   output logic                 busy,
   output logic                 done
);

   localparam logic [LOC_SIZE-1:0] MIN_AREA_V = LOC_SIZE'(MIN_AREA);
   localparam logic [7:0]          WAIT_INIT  = 8'(RD_LATENCY - 1);

   cr_state_t            state;
   logic [LBL_WIDTH-1:0] cur;
   logic [LBL_WIDTH-1:0] last;
   logic [7:0]           wait_cnt;
   logic                 at_last;
   logic                 div_start;
   logic                 x_busy;
   logic                 y_busy;
   logic [LOC_SIZE-1:0]  x_quo;
   logic [LOC_SIZE-1:0]  y_quo;

   // The read address is the current label itself, so it is already stable
   // during ISSUE and the table data lines up with CAPTURE.
   assign obj_id    = cur;
   assign at_last   = (cur == last - 1'b1);
   assign div_start = (state == CR_CAPTURE) && (obj_area >= MIN_AREA_V) && (obj_area != '0);

   udiv_seq #(.WIDTH(LOC_SIZE)) u_div_x (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (div_start),
      .dividend (obj_x),
      .divisor  (obj_area),
      .busy     (x_busy),
      .quotient (x_quo)
   );

   udiv_seq #(.WIDTH(LOC_SIZE)) u_div_y (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (div_start),
      .dividend (obj_y),
      .divisor  (obj_area),
      .busy     (y_busy),
      .quotient (y_quo)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= CR_IDLE;
         cur       <= '0;
         last      <= '0;
         wait_cnt  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
         out_id    <= '0;
         out_area  <= '0;
         out_cx    <= '0;
         out_cy    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            CR_IDLE: begin
               if (start) begin
                  last  <= num_labels;
                  cur   <= LBL_WIDTH'(1);
                  busy  <= 1'b1;
                  state <= (num_labels <= LBL_WIDTH'(1)) ? CR_FIN : CR_ISSUE;
               end
            end
            CR_ISSUE: begin
               wait_cnt <= WAIT_INIT;
               state    <= (RD_LATENCY == 1) ? CR_CAPTURE : CR_WAIT;
            end
            CR_WAIT: begin
               wait_cnt <= wait_cnt - 1'b1;
               if (wait_cnt <= 8'd1) begin
                  state <= CR_CAPTURE;
               end
            end
            // Undersized objects are dropped here; a zero area can only get
            // past the size filter when MIN_AREA is 0 and must not be divided.
            CR_CAPTURE: begin
               out_id   <= cur;
               out_area <= obj_area;
               if (obj_area < MIN_AREA_V) begin
                  if (at_last) begin
                     state <= CR_FIN;
                  end else begin
                     cur   <= cur + 1'b1;
                     state <= CR_ISSUE;
                  end
               end else if (obj_area == '0) begin
                  out_cx    <= '0;
                  out_cy    <= '0;
                  out_valid <= 1'b1;
                  state     <= CR_EMIT;
               end else begin
                  state <= CR_DIVIDE;
               end
            end
            CR_DIVIDE: begin
               if (!(x_busy || y_busy)) begin
                  out_cx    <= x_quo;
                  out_cy    <= y_quo;
                  out_valid <= 1'b1;
                  state     <= CR_EMIT;
               end
            end
            CR_EMIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (at_last) begin
                     state <= CR_FIN;
                  end else begin
                     cur   <= cur + 1'b1;
                     state <= CR_ISSUE;
                  end
               end
            end
            CR_FIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= CR_IDLE;
            end
            default: state <= CR_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_object_centroid_reader.sv
// Self-checking bench for object_centroid_reader: table-driven sweeps, a
// randomized sweep loop against a table-level model, and reset/stall corners.
module tb_object_centroid_reader;

   localparam int LBL  = 6;
   localparam int LOC  = 8;
   localparam int RDL  = 2;
   localparam int MINA = 2;

   typedef struct {
      logic [5:0] id;
      logic [7:0] area;
      logic [7:0] cx;
      logic [7:0] cy;
   } rec_t;

   typedef struct {
      logic [5:0] nl;
      logic [7:0] a1, x1, y1, a2, x2, y2;
      int         hold;
      bit         disturb;
      int         n_exp;
      rec_t       r0;
      rec_t       r1;
   } vec_t;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic           start = 1'b0;
   logic [LBL-1:0] num_labels = '0;
   logic [LBL-1:0] obj_id;
   logic [LOC-1:0] obj_area, obj_x, obj_y;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [LBL-1:0] out_id;
   logic [LOC-1:0] out_area, out_cx, out_cy;
   logic           busy, done;

   logic [7:0] tbl_a [64];
   logic [7:0] tbl_x [64];
   logic [7:0] tbl_y [64];
   logic [LBL-1:0] id_d1 = '0, id_d2 = '0;

   rec_t got_q[$];
   rec_t exp_q[$];
   int   id_seq[$];
   int   prev_id;
   int   exp_cyc;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // Labeller table with a two-cycle address-to-data read latency.
   always @(posedge clk) begin
      id_d1 <= obj_id;
      id_d2 <= id_d1;
   end
   assign obj_area = tbl_a[id_d2];
   assign obj_x    = tbl_x[id_d2];
   assign obj_y    = tbl_y[id_d2];

   object_centroid_reader #(
      .LBL_WIDTH (LBL),
      .LOC_SIZE  (LOC),
      .RD_LATENCY(RDL),
      .MIN_AREA  (MINA)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .num_labels(num_labels),
      .obj_id    (obj_id),
      .obj_area  (obj_area),
      .obj_x     (obj_x),
      .obj_y     (obj_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_id    (out_id),
      .out_area  (out_area),
      .out_cx    (out_cx),
      .out_cy    (out_cy),
      .busy      (busy),
      .done      (done)
   );

   always @(negedge clk) begin
      if (out_valid && out_ready) got_q.push_back('{out_id, out_area, out_cx, out_cy});
      if (busy && int'(obj_id) != prev_id) begin
         id_seq.push_back(int'(obj_id));
         prev_id = int'(obj_id);
      end
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: every label in 1..last-1 that meets the size floor yields a
   // floor-divided centroid; sweep length follows the per-label cycle costs.
   task automatic modelSweep(input int last, input int hold);
      exp_q.delete();
      exp_cyc = 2;
      for (int id = 1; id < last; id++) begin
         if (int'(tbl_a[id]) < MINA) begin
            exp_cyc += 1 + RDL;
         end else begin
            exp_q.push_back('{6'(id), tbl_a[id], tbl_x[id] / tbl_a[id], tbl_y[id] / tbl_a[id]});
            exp_cyc += 2 + RDL + LOC;
         end
      end
      if (exp_q.size() > 0) exp_cyc += hold;
   endtask

   task automatic applyStimulus(input logic [5:0] nl, input int hold, input bit disturb,
                                output int cyc);
      int         hold_left;
      int         unstable;
      bit         seen;
      rec_t       snap;
      got_q.delete();
      id_seq.delete();
      prev_id    = 0;
      num_labels = nl;
      out_ready  = (hold == 0);
      seen       = 1'b0;
      unstable   = 0;
      hold_left  = 0;
      snap       = '{6'd0, 8'd0, 8'd0, 8'd0};
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc   = 1;
      while (!done && cyc < 2000) begin
         if (disturb && cyc == 3) num_labels = 6'd9;
         if (disturb) start = (cyc == 5);
         if (out_valid && !seen) begin
            seen      = 1'b1;
            hold_left = hold;
            snap      = '{out_id, out_area, out_cx, out_cy};
         end else if (hold_left > 0) begin
            if (!out_valid || out_id != snap.id || out_area != snap.area ||
                out_cx != snap.cx || out_cy != snap.cy) unstable++;
            hold_left--;
            if (hold_left == 0) out_ready = 1'b1;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start     = 1'b0;
      out_ready = 1'b1;
      if (hold > 0) checkOutput("stall_stable", unstable, 0);
      checkOutput("done_seen", int'(done), 1);
      @(posedge clk); #1;
      checkOutput("done_one_cycle", int'(done), 0);
      checkOutput("busy_after_done", int'(busy), 0);
   endtask

   task automatic compareRecords(input string tag);
      checkOutput({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checkOutput({tag, "_id"},   int'(got_q[i].id),   int'(exp_q[i].id));
         checkOutput({tag, "_area"}, int'(got_q[i].area), int'(exp_q[i].area));
         checkOutput({tag, "_cx"},   int'(got_q[i].cx),   int'(exp_q[i].cx));
         checkOutput({tag, "_cy"},   int'(got_q[i].cy),   int'(exp_q[i].cy));
      end
   endtask

   task automatic checkIdSeq(input string tag, input int last);
      if (last >= 2) begin
         checkOutput({tag, "_idseq_len"}, id_seq.size(), last - 1);
         for (int i = 0; i < id_seq.size() && i < last - 1; i++)
            checkOutput({tag, "_idseq"}, id_seq[i], i + 1);
      end
   endtask

   vec_t vecs[9];
   int   cyc;

   initial begin
      vecs[0] = '{6'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 0, 1'b0, 0,
                  '{6'd0, 8'd0, 8'd0, 8'd0}, '{6'd0, 8'd0, 8'd0, 8'd0}};
      vecs[1] = '{6'd3, 8'd4, 8'd40, 8'd8, 8'd3, 8'd10, 8'd7, 0, 1'b0, 2,
                  '{6'd1, 8'd4, 8'd10, 8'd2}, '{6'd2, 8'd3, 8'd3, 8'd2}};
      vecs[2] = '{6'd3, 8'd1, 8'd9, 8'd9, 8'd5, 8'd25, 8'd50, 0, 1'b0, 1,
                  '{6'd2, 8'd5, 8'd5, 8'd10}, '{6'd0, 8'd0, 8'd0, 8'd0}};
      vecs[3] = '{6'd2, 8'd7, 8'd100, 8'd13, 8'd9, 8'd9, 8'd9, 0, 1'b0, 1,
                  '{6'd1, 8'd7, 8'd14, 8'd1}, '{6'd0, 8'd0, 8'd0, 8'd0}};
      vecs[4] = '{6'd0, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 0, 1'b0, 0,
                  '{6'd0, 8'd0, 8'd0, 8'd0}, '{6'd0, 8'd0, 8'd0, 8'd0}};
      vecs[5] = '{6'd3, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd254, 0, 1'b0, 1,
                  '{6'd2, 8'd255, 8'd1, 8'd0}, '{6'd0, 8'd0, 8'd0, 8'd0}};
      vecs[6] = '{6'd3, 8'd2, 8'd3, 8'd255, 8'd1, 8'd0, 8'd0, 0, 1'b0, 1,
                  '{6'd1, 8'd2, 8'd1, 8'd127}, '{6'd0, 8'd0, 8'd0, 8'd0}};
      vecs[7] = '{6'd3, 8'd4, 8'd40, 8'd8, 8'd3, 8'd10, 8'd7, 20, 1'b0, 2,
                  '{6'd1, 8'd4, 8'd10, 8'd2}, '{6'd2, 8'd3, 8'd3, 8'd2}};
      vecs[8] = '{6'd3, 8'd4, 8'd40, 8'd8, 8'd3, 8'd10, 8'd7, 0, 1'b1, 2,
                  '{6'd1, 8'd4, 8'd10, 8'd2}, '{6'd2, 8'd3, 8'd3, 8'd2}};

      for (int i = 0; i < 64; i++) begin
         tbl_a[i] = 8'd6;
         tbl_x[i] = 8'd60;
         tbl_y[i] = 8'd30;
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", int'(out_valid), 0);
      checkOutput("rst_busy",      int'(busy), 0);
      checkOutput("rst_done",      int'(done), 0);
      checkOutput("rst_obj_id",    int'(obj_id), 0);
      checkOutput("rst_out_id",    int'(out_id), 0);
      checkOutput("rst_out_area",  int'(out_area), 0);
      checkOutput("rst_out_cx",    int'(out_cx), 0);
      checkOutput("rst_out_cy",    int'(out_cy), 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Table-driven sweeps
      for (int v = 0; v < 9; v++) begin
         tbl_a[1] = vecs[v].a1; tbl_x[1] = vecs[v].x1; tbl_y[1] = vecs[v].y1;
         tbl_a[2] = vecs[v].a2; tbl_x[2] = vecs[v].x2; tbl_y[2] = vecs[v].y2;
         modelSweep(int'(vecs[v].nl), vecs[v].hold);
         exp_q.delete();
         if (vecs[v].n_exp > 0) exp_q.push_back(vecs[v].r0);
         if (vecs[v].n_exp > 1) exp_q.push_back(vecs[v].r1);
         applyStimulus(vecs[v].nl, vecs[v].hold, vecs[v].disturb, cyc);
         $display("[TB] vector %0d: num_labels=%0d records=%0d cycles=%0d",
                  v, vecs[v].nl, got_q.size(), cyc);
         compareRecords($sformatf("vec%0d", v));
         checkOutput($sformatf("vec%0d_cycles", v), cyc, exp_cyc);
         checkIdSeq($sformatf("vec%0d", v), int'(vecs[v].nl));
      end

      // Reset in the middle of id2's divide, then a clean re-sweep
      tbl_a[1] = 8'd4; tbl_x[1] = 8'd40; tbl_y[1] = 8'd8;
      tbl_a[2] = 8'd3; tbl_x[2] = 8'd10; tbl_y[2] = 8'd7;
      got_q.delete();
      num_labels = 6'd3;
      out_ready  = 1'b1;
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (17) begin
         @(posedge clk); #1;
      end
      checkOutput("pre_reset_obj_id",  int'(obj_id), 2);
      checkOutput("pre_reset_records", got_q.size(), 1);
      reset_n = 1'b0;
      @(posedge clk); #1;
      checkOutput("mid_reset_out_valid", int'(out_valid), 0);
      checkOutput("mid_reset_busy",      int'(busy), 0);
      checkOutput("mid_reset_obj_id",    int'(obj_id), 0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      modelSweep(3, 0);
      applyStimulus(6'd3, 0, 1'b0, cyc);
      compareRecords("resweep");
      checkOutput("resweep_cycles", cyc, exp_cyc);
      checkIdSeq("resweep", 3);

      // Randomized tables against the model
      for (int r = 0; r < 12; r++) begin
         int nl, hold;
         nl   = $urandom_range(0, 7);
         hold = $urandom_range(0, 3);
         for (int i = 1; i < 64; i++) begin
            tbl_a[i] = 8'($urandom_range(0, 12));
            tbl_x[i] = 8'($urandom_range(0, 255));
            tbl_y[i] = 8'($urandom_range(0, 255));
         end
         modelSweep(nl, hold);
         applyStimulus(6'(nl), hold, 1'b0, cyc);
         compareRecords($sformatf("rnd%0d", r));
         checkOutput($sformatf("rnd%0d_cycles", r), cyc, exp_cyc);
         checkIdSeq($sformatf("rnd%0d", r), nl);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
